// File: rtl/idli_gpio.sv
// GPIO block for a nibble-serial datapath: synchronised and optionally debounced
// inputs with sticky edge flags, plus an output register written 4 bits per slice.
module idli_gpio #(
    parameter int NUM_PINS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_PINS-1:0] i_pins,
    output logic [NUM_PINS-1:0] o_pins,
    input  logic [1:0]          i_ctr,
    input  logic                i_wr_en,
    input  logic [1:0]          i_wr_mode,
    input  logic [3:0]          i_wr_slice,
    input  logic                i_rd_en,
    input  logic [1:0]          i_rd_sel,
    output logic [3:0]          o_rd_slice,
    output logic                o_rd_any
);

    typedef enum logic [1:0] {WR_WRITE, WR_SET, WR_CLR, WR_TOGGLE} wr_mode_e;
    typedef enum logic [1:0] {RD_LEVEL, RD_RISE, RD_FALL, RD_OUT} rd_sel_e;

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_out;
    logic [NUM_PINS-1:0] filt;
    logic [NUM_PINS-1:0] filt_d;
    logic [NUM_PINS-1:0] rise_flags;
    logic [NUM_PINS-1:0] fall_flags;
    logic [NUM_PINS-1:0] rise_clr;
    logic [NUM_PINS-1:0] fall_clr;
    logic [NUM_PINS-1:0] op_pins;
    logic [NUM_PINS-1:0] o_next;
    logic [11:0]         wr_acc;
    logic                wr_ok;
    logic                wr_fire;
    logic [15:0]         op;
    logic [15:0]         rd_src;
    logic [15:0]         snap;
    logic                rd_last;

    // NOTE: the synchroniser is a small flop array, not a RAM, so every stage is
    // reset explicitly; a RAM-style array would have no reset and must not be cleared here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= i_pins;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign filt = sync_out;
        end else begin : g_filt
            localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN);
            logic [NUM_PINS-1:0] filt_q;
            logic [3:0]          cnt [NUM_PINS];

            // A pin flips only after FILTER_LEN+1 consecutive disagreeing samples.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    filt_q <= '0;
                    for (int p = 0; p < NUM_PINS; p++) cnt[p] <= '0;
                end else begin
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (sync_out[p] != filt_q[p]) begin
                            if (cnt[p] == FILT_MAX) begin
                                filt_q[p] <= sync_out[p];
                                cnt[p]    <= '0;
                            end else begin
                                cnt[p] <= cnt[p] + 4'd1;
                            end
                        end else begin
                            cnt[p] <= '0;
                        end
                    end
                end
            end

            assign filt = filt_q;
        end

        if (NUM_PINS < 16) begin : g_unused
            logic unused_op_bits;
            assign unused_op_bits = ^op[15:NUM_PINS];
        end
    endgenerate

    assign rd_last  = i_rd_en && (i_ctr == 2'd3);
    assign rise_clr = (rd_last && i_rd_sel == RD_RISE) ? snap[NUM_PINS-1:0] : '0;
    assign fall_clr = (rd_last && i_rd_sel == RD_FALL) ? snap[NUM_PINS-1:0] : '0;

    // A fresh edge is ORed in after the clear so it survives a concurrent read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_d     <= '0;
            rise_flags <= '0;
            fall_flags <= '0;
        end else begin
            filt_d     <= filt;
            rise_flags <= (rise_flags & ~rise_clr) | (filt & ~filt_d);
            fall_flags <= (fall_flags & ~fall_clr) | (~filt & filt_d);
        end
    end

    assign op      = {i_wr_slice, wr_acc};
    assign op_pins = op[NUM_PINS-1:0];
    assign wr_fire = i_wr_en && (i_ctr == 2'd3) && wr_ok;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        o_next = o_pins;
        unique case (wr_mode_e'(i_wr_mode))
            WR_WRITE:  o_next = op_pins;
            WR_SET:    o_next = o_pins | op_pins;
            WR_CLR:    o_next = o_pins & ~op_pins;
            WR_TOGGLE: o_next = o_pins ^ op_pins;
        endcase
    end

    always_comb begin
        rd_src = '0;
        unique case (rd_sel_e'(i_rd_sel))
            RD_LEVEL: rd_src[NUM_PINS-1:0] = filt;
            RD_RISE:  rd_src[NUM_PINS-1:0] = rise_flags;
            RD_FALL:  rd_src[NUM_PINS-1:0] = fall_flags;
            RD_OUT:   rd_src[NUM_PINS-1:0] = o_pins;
        endcase
    end

    // wr_ok stays high only while i_wr_en has been held since slice 0.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pins <= '0;
            wr_acc <= '0;
            wr_ok  <= 1'b0;
            snap   <= '0;
        end else begin
            if (i_wr_en) begin
                unique case (i_ctr)
                    2'd0:    wr_acc[3:0]  <= i_wr_slice;
                    2'd1:    wr_acc[7:4]  <= i_wr_slice;
                    2'd2:    wr_acc[11:8] <= i_wr_slice;
                    default: ;
                endcase
            end
            wr_ok <= i_wr_en && ((i_ctr == 2'd0) || (wr_ok && i_ctr != 2'd3));
            if (wr_fire) o_pins <= o_next;
            if (i_rd_en && i_ctr == 2'd0) snap <= rd_src;
        end
    end

    always_comb begin
        o_rd_slice = '0;
        o_rd_any   = 1'b0;
        if (i_rd_en) begin
            unique case (i_ctr)
                2'd0: o_rd_slice = rd_src[3:0];
                2'd1: o_rd_slice = snap[7:4];
                2'd2: o_rd_slice = snap[11:8];
                2'd3: begin
                    o_rd_slice = snap[15:12];
                    o_rd_any   = |snap;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_gpio.sv
// Directed bench for idli_gpio: a write/readback vector table plus hand-written
// sequences for synchroniser latency, debounce, flag clearing and mid-instruction reset.
module tb_idli_gpio;

    localparam logic [1:0] M_WRITE = 2'd0, M_SET = 2'd1, M_CLR = 2'd2, M_TOG = 2'd3;
    localparam logic [1:0] S_LEVEL = 2'd0, S_RISE = 2'd1, S_FALL = 2'd2, S_OUT = 2'd3;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] op;
        logic [3:0]  mask;    // per-slice write enable, bit c = slice c
        logic [3:0]  exp_a;   // o_pins of 4-pin instances after the write
        logic [15:0] exp_w;   // o_pins of 16-pin instance after the write
        logic [3:0]  exp_rd;  // OUT readback (value before the write)
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ctr = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_mode = '0;
    logic [3:0]  wr_slice = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_sel = '0;
    logic [3:0]  pins_a = '0;
    logic [3:0]  pins_f = '0;
    logic [15:0] pins_w = 16'h0002;
    logic [3:0]  o_pins_a, o_pins_f;
    logic [15:0] o_pins_w;
    logic [3:0]  rd_slice_a, rd_slice_f, rd_slice_w;
    logic        rd_any_a, rd_any_f, rd_any_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idli_gpio #(.NUM_PINS(4), .SYNC_STAGES(2), .FILTER_LEN(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_pins(pins_a), .o_pins(o_pins_a), .i_ctr(ctr),
        .i_wr_en(wr_en), .i_wr_mode(wr_mode), .i_wr_slice(wr_slice), .i_rd_en(rd_en),
        .i_rd_sel(rd_sel), .o_rd_slice(rd_slice_a), .o_rd_any(rd_any_a)
    );

    idli_gpio #(.NUM_PINS(4), .SYNC_STAGES(2), .FILTER_LEN(3)) u_f (
        .i_clk(clk), .i_rst(rst), .i_pins(pins_f), .o_pins(o_pins_f), .i_ctr(ctr),
        .i_wr_en(wr_en), .i_wr_mode(wr_mode), .i_wr_slice(wr_slice), .i_rd_en(rd_en),
        .i_rd_sel(rd_sel), .o_rd_slice(rd_slice_f), .o_rd_any(rd_any_f)
    );

    idli_gpio #(.NUM_PINS(16), .SYNC_STAGES(2), .FILTER_LEN(0)) u_w (
        .i_clk(clk), .i_rst(rst), .i_pins(pins_w), .o_pins(o_pins_w), .i_ctr(ctr),
        .i_wr_en(wr_en), .i_wr_mode(wr_mode), .i_wr_slice(wr_slice), .i_rd_en(rd_en),
        .i_rd_sel(rd_sel), .o_rd_slice(rd_slice_w), .o_rd_any(rd_any_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ctr = '0; wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    // One 4-slice instruction; inst selects whose read slices are captured
    // (0 = u_a, 1 = u_w, 2 = u_f) and whose pins change at slice chg_at.
    task automatic instr(input logic wen, input logic [1:0] mode, input logic [15:0] op,
                         input logic [3:0] mask, input logic ren, input logic [1:0] rsel,
                         input int chg_at, input logic [15:0] chg_val, input int inst,
                         output logic [15:0] rs, output logic ra, output logic [3:0] pre_o);
        rs = '0; ra = 1'b0; pre_o = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ctr = 2'(c); wr_en = wen & mask[c]; wr_mode = mode; wr_slice = op[4*c +: 4];
            rd_en = ren; rd_sel = rsel;
            if (c == chg_at) begin
                if (inst == 1) pins_w = chg_val;
                else if (inst == 2) pins_f = chg_val[3:0];
                else pins_a = chg_val[3:0];
            end
            #1;
            case (inst)
                1: rs[4*c +: 4] = rd_slice_w;
                2: rs[4*c +: 4] = rd_slice_f;
                default: rs[4*c +: 4] = rd_slice_a;
            endcase
            if (c == 3) begin
                ra = (inst == 1) ? rd_any_w : (inst == 2) ? rd_any_f : rd_any_a;
                pre_o = o_pins_a;
            end
        end
        @(negedge clk);
        ctr = '0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        logic [15:0] rs;
        logic        ra;
        logic [3:0]  po;

        vecs[0]  = '{M_WRITE, 16'h000A, 4'b1111, 4'hA, 16'h000A, 4'h0};
        vecs[1]  = '{M_SET,   16'h0005, 4'b1111, 4'hF, 16'h000F, 4'hA};
        vecs[2]  = '{M_CLR,   16'h0003, 4'b1111, 4'hC, 16'h000C, 4'hF};
        vecs[3]  = '{M_TOG,   16'h0006, 4'b1111, 4'hA, 16'h000A, 4'hC};
        vecs[4]  = '{M_TOG,   16'h000F, 4'b1011, 4'hA, 16'h000A, 4'hA};
        vecs[5]  = '{M_WRITE, 16'hFFF5, 4'b1111, 4'h5, 16'hFFF5, 4'hA};
        vecs[6]  = '{M_WRITE, 16'h0003, 4'b1110, 4'h5, 16'hFFF5, 4'h5};
        vecs[7]  = '{M_CLR,   16'hFFF4, 4'b1111, 4'h1, 16'h0001, 4'h5};
        vecs[8]  = '{M_SET,   16'h0000, 4'b1111, 4'h1, 16'h0001, 4'h1};
        vecs[9]  = '{M_TOG,   16'h1231, 4'b1111, 4'h0, 16'h1230, 4'h1};
        vecs[10] = '{M_WRITE, 16'h0009, 4'b1111, 4'h9, 16'h0009, 4'h0};

        // Reset state; u_w pin1 is held high throughout reset.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b1; ctr = '0; rd_sel = S_RISE;
        #1;
        check("reset o_pins_a", 32'(o_pins_a), 32'h0);
        check("reset o_pins_f", 32'(o_pins_f), 32'h0);
        check("reset o_pins_w", 32'(o_pins_w), 32'h0);
        check("reset rise live k0", 32'(rd_slice_w), 32'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-reset rise live k%0d", k), 32'(rd_slice_w),
                  (k == 3) ? 32'h2 : 32'h0);
        end
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_RISE, -1, 16'h0, 1, rs, ra, po);
        check("post-reset rise read", 32'(rs), 32'h0002);
        check("post-reset rise any", 32'(ra), 32'h1);

        // Write table with concurrent OUT readback.
        for (int i = 0; i < 11; i++) begin
            instr(1'b1, vecs[i].mode, vecs[i].op, vecs[i].mask, 1'b1, S_OUT, -1, 16'h0, 0,
                  rs, ra, po);
            check($sformatf("vec%0d o_pins_a", i), 32'(o_pins_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d o_pins_f", i), 32'(o_pins_f), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d o_pins_w", i), 32'(o_pins_w), 32'(vecs[i].exp_w));
            check($sformatf("vec%0d out read", i), 32'(rs), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d out any", i), 32'(ra), 32'(vecs[i].exp_rd != 4'h0));
            check($sformatf("vec%0d o_pins before edge", i), 32'(po), 32'(vecs[i].exp_rd));
        end

        // Debounce on u_f: a 3-cycle pulse is rejected, a 5-cycle pulse flags at cycle 7.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ctr = '0; rd_en = 1'b1; rd_sel = S_RISE;
            pins_f = (k < 3) ? 4'h1 : 4'h0;
            #1;
            check($sformatf("filter short pulse k%0d", k), 32'(rd_slice_f), 32'h0);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pins_f = (k < 5) ? 4'h1 : 4'h0;
            #1;
            check($sformatf("filter long pulse k%0d", k), 32'(rd_slice_f),
                  (k >= 7) ? 32'h1 : 32'h0);
        end
        idle(2);

        // LEVEL snapshot on u_w is immune to a pin change at slice 1.
        @(negedge clk);
        pins_w = 16'h1234;
        idle(6);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_LEVEL, 1, 16'hFFFF, 1, rs, ra, po);
        check("level snapshot", 32'(rs), 32'h1234);
        check("level any", 32'(ra), 32'h1);
        idle(5);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_RISE, -1, 16'h0, 1, rs, ra, po);
        check("wide rise read", 32'(rs), 32'hFFFF);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_RISE, -1, 16'h0, 1, rs, ra, po);
        check("wide rise cleared", 32'(rs), 32'h0000);
        check("wide rise cleared any", 32'(ra), 32'h0);
        @(negedge clk);
        pins_w = 16'h00F0;
        idle(5);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_FALL, -1, 16'h0, 1, rs, ra, po);
        check("wide fall read", 32'(rs), 32'hFF0F);

        // RISE read on u_a while pin2 rises in the clearing cycle.
        @(negedge clk);
        pins_a = 4'h3;
        idle(5);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_RISE, 1, 16'h0007, 0, rs, ra, po);
        check("rise read during new edge", 32'(rs), 32'h0003);
        check("rise any during new edge", 32'(ra), 32'h1);
        idle(3);
        instr(1'b0, M_WRITE, 16'h0, 4'hF, 1'b1, S_RISE, -1, 16'h0, 0, rs, ra, po);
        check("rise flags after clear", 32'(rs), 32'h0004);

        // Reset at slice 2 of a WRITE 0xF aborts it; a clean write follows.
        @(negedge clk);
        ctr = 2'd0; wr_en = 1'b1; wr_mode = M_WRITE; wr_slice = 4'hF; rd_en = 1'b0;
        @(negedge clk);
        ctr = 2'd1; wr_slice = 4'h0;
        @(negedge clk);
        ctr = 2'd2; rst = 1'b1;
        @(negedge clk);
        ctr = 2'd3; rst = 1'b0;
        @(negedge clk);
        ctr = 2'd0; wr_en = 1'b0;
        #1;
        check("reset mid-write o_pins_a", 32'(o_pins_a), 32'h0);
        check("reset mid-write o_pins_w", 32'(o_pins_w), 32'h0);
        instr(1'b1, M_WRITE, 16'h0006, 4'hF, 1'b1, S_OUT, -1, 16'h0, 0, rs, ra, po);
        check("clean write after reset", 32'(o_pins_a), 32'h6);
        check("clean write out read", 32'(rs), 32'h0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
